// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: baud divisors (12 MHz clock), frame lengths, FSM states.
// UART_TX_PARITY_EN adds the PARITY state used for 8E1 framing.
package uart_tx_pkg;

  localparam int unsigned B115200 = 104;
  localparam int unsigned B57600  = 208;
  localparam int unsigned B38400  = 313;
  localparam int unsigned B19200  = 625;
  localparam int unsigned B9600   = 1250;
  localparam int unsigned B4800   = 2500;
  localparam int unsigned B2400   = 5000;
  localparam int unsigned B1200   = 10000;
  localparam int unsigned B600    = 20000;
  localparam int unsigned B300    = 40000;

  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_baudgen.sv
// Bit-period timer: counts 0..BAUDRATE-1 while enabled, pulses clk_out on the last cycle of each bit.
module baudgen_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUDRATE = B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_ena,
  output logic clk_out
);

  localparam logic [15:0] TERM = 16'(BAUDRATE - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !clk_ena) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign clk_out = clk_ena && (r_cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line, start/ready handshake.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity between bit 7 and stop).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_tx;
  logic       r_ready;
  logic       w_baud_ena;
  logic       w_baud_tick;
`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`endif

  // Timer runs only while a frame is in flight, so it is zero at acceptance.
  assign w_baud_ena = (r_state != ST_IDLE);

  baudgen_tx #(
    .BAUDRATE(BAUDRATE)
  ) u_baudgen (
    .clk    (clk),
    .rst    (rst),
    .clk_ena(w_baud_ena),
    .clk_out(w_baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= data;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data;
`endif
          end
        end
        ST_START: begin
          if (w_baud_tick) begin
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= '0;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_baud_tick) begin
            if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              // Shift register is pre-advanced, so shift[0] is always the next bit.
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_baud_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_baud_tick) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed cases plus random bytes against a frame-level model.
// Honours UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int unsigned BR = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = FRAME_BITS_8E1;
`else
  localparam int NB = FRAME_BITS_8N1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic       tx;
  logic       ready;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.BAUDRATE(BR)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .tx   (tx),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: bit k of the serial frame for byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Call at the negedge just after the accepting edge (frame cycle 0).
  task automatic run_frame(input logic [7:0] b, input int ign_at, input int rst_at,
                           input logic chain, input logic [7:0] nxt);
    for (int j = 0; j < NB * int'(BR); j++) begin
      if (j == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        rst = 1'b0;
        return;
      end
      chk("tx_bit", tx, exp_bit(b, j / int'(BR)));
      chk("busy", ready, 0);
      if (j == 0) begin
        start = 1'b0;
        data  = 8'($urandom);
      end
      if (j == ign_at) begin
        start = 1'b1;
        data  = 8'hFF;
      end
      if (j == ign_at + 1) start = 1'b0;
      if (chain && j == NB * int'(BR) - 1) begin
        start = 1'b1;
        data  = nxt;
      end
      @(negedge clk);
    end
    chk("ready_ret", ready, 1);
    chk("tx_stop_idle", tx, 1);
    if (chain) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] b);
    data  = b;
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", tx, 1);
      chk("idle_ready", ready, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] nb;
    logic       ch;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(50);

    accept(8'h55);
    run_frame(8'h55, -1, -1, 1'b0, 8'h00);
    idle_cycles(3);

    accept(8'h4B);
    run_frame(8'h4B, -1, -1, 1'b1, 8'h00);
    run_frame(8'h00, -1, -1, 1'b0, 8'h00);
    idle_cycles(3);

    accept(8'h55);
    run_frame(8'h55, 12, -1, 1'b0, 8'h00);
    idle_cycles(2 * NB * int'(BR));

    accept(8'h00);
    run_frame(8'h00, -1, 17, 1'b0, 8'h00);
    idle_cycles(5);
    accept(8'hA5);
    run_frame(8'hA5, -1, -1, 1'b0, 8'h00);
    idle_cycles(2);

    // Simultaneous start and reset: reset wins and nothing is launched.
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    chk("rst_start_tx", tx, 1);
    chk("rst_start_ready", ready, 1);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    idle_cycles(4);

`ifdef UART_TX_PARITY_EN
    accept(8'h07);
    run_frame(8'h07, -1, -1, 1'b0, 8'h00);
    idle_cycles(2);
`endif

    b = 8'($urandom);
    accept(b);
    for (int n = 0; n < 20; n++) begin
      ch = 1'($urandom_range(0, 1));
      nb = 8'($urandom);
      run_frame(b, (n % 3 == 0) ? int'($urandom_range(2, 30)) : -1, -1, ch, nb);
      if (!ch) begin
        idle_cycles(int'($urandom_range(1, 6)));
        accept(nb);
      end
      b = nb;
    end
    run_frame(b, -1, -1, 1'b0, 8'h00);
    idle_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
